// File: rtl/cb_filter_pkg.sv
// Shared seed type for the Bloom-filter front ends: per-channel permutation
// seed and XOR key.
package cb_filter_pkg;

    typedef struct packed {
        int unsigned PermuteSeed;
        int unsigned XorSeed;
    } cb_seed_t;

endpackage

// File: rtl/sub_per_hash_seq_pkg.sv
// Types and elaboration-time helpers for the iterative SP hash: LCG-driven
// bit-permutation generator, rotating XOR mask and the FSM state enum.
package sub_per_hash_seq_pkg;

    localparam int unsigned LcgMul      = 32'd1103515245;
    localparam int unsigned LcgInc      = 32'd12345;
    localparam int          MaxInpWidth = 256;

    // Entry j holds the source bit index feeding output bit j.
    typedef logic [MaxInpWidth-1:0][15:0] perm_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    // Fisher-Yates shuffle of the identity, driven by a 32-bit LCG.
    function automatic perm_idx_t perm_gen(input logic [31:0] seed_in, input int width);
        perm_idx_t   perm;
        logic [31:0] seed;
        logic [15:0] tmp;
        int          sel;
        perm = '0;
        for (int k = 0; k < width; k++) perm[k] = 16'(k);
        seed = seed_in;
        for (int k = width - 1; k >= 1; k--) begin
            seed      = seed * LcgMul + LcgInc;
            sel       = int'(seed % 32'(k + 1));
            tmp       = perm[k];
            perm[k]   = perm[sel];
            perm[sel] = tmp;
        end
        return perm;
    endfunction

    // Bit j of the result is seed[(j + r) mod 32].
    function automatic logic [31:0] xor_mask(input logic [31:0] seed, input logic [4:0] r);
        logic [63:0] dbl;
        dbl = {seed, seed};
        return dbl[{1'b0, r} +: 32];
    endfunction

endpackage

// File: rtl/sub_per_hash_seq_if.sv
// Word-in / hashes-out handshake bundle for sub_per_hash_seq.
interface sub_per_hash_seq_if #(
    parameter int InpWidth  = 32,
    parameter int HashWidth = 5,
    parameter int NoHashes  = 3
);
    logic [InpWidth-1:0]                     in_data_i;
    logic                                    in_valid_i;
    logic                                    in_ready_o;
    logic [NoHashes-1:0][HashWidth-1:0]      hash_o;
    logic [NoHashes-1:0][2**HashWidth-1:0]   hash_onehot_o;
    logic                                    out_valid_o;
    logic                                    out_ready_i;

    modport master (
        output in_data_i, in_valid_i, out_ready_i,
        input  in_ready_o, hash_o, hash_onehot_o, out_valid_o
    );

    modport slave (
        input  in_data_i, in_valid_i, out_ready_i,
        output in_ready_o, hash_o, hash_onehot_o, out_valid_o
    );
endinterface

// File: rtl/sub_per_hash_round.sv
// One combinational substitution-permutation round for a single keyed channel:
// fixed permutation, round-rotated XOR key, chi-style nonlinear layer.
module sub_per_hash_round
    import sub_per_hash_seq_pkg::*;
#(
    parameter int          InpWidth   = 32,
    parameter logic [31:0] PermuteKey = 32'd0,
    parameter logic [31:0] XorKey     = 32'd0
) (
    input  logic [4:0]          round_i,
    input  logic [InpWidth-1:0] state_i,
    output logic [InpWidth-1:0] state_o
);

    localparam perm_idx_t Perm = perm_gen(PermuteKey, InpWidth);

    logic [InpWidth-1:0] p;
    logic [InpWidth-1:0] x;
    logic [31:0]         mask;

    assign mask = xor_mask(XorKey, round_i);

    for (genvar j = 0; j < InpWidth; j++) begin : g_bit
        localparam int Src = int'(Perm[j]);
        assign p[j]       = state_i[Src];
        assign x[j]       = p[j] ^ mask[j % 32];
        assign state_o[j] = x[j] ^ (x[(j + 1) % InpWidth] & ~x[(j + 2) % InpWidth]);
    end

endmodule

// File: rtl/sub_per_hash_seq.sv
// Iterative multi-channel SP hash: one round per cycle per channel, folded
// hashes registered on entry to DONE. Define SUB_PER_HASH_SEQ_FLUSH_EN for flush_i.
module sub_per_hash_seq
    import sub_per_hash_seq_pkg::*;
    import cb_filter_pkg::*;
#(
    parameter int                       InpWidth  = 32,
    parameter int                       HashWidth = 5,
    parameter int                       NoHashes  = 3,
    parameter int                       NoRounds  = 4,
    parameter cb_seed_t [NoHashes-1:0]  Seeds     = '{
        '{PermuteSeed: 32'd299034753, XorSeed: 32'd4094834},
        '{PermuteSeed: 32'd19921030,  XorSeed: 32'd995713},
        '{PermuteSeed: 32'd294388,    XorSeed: 32'd65146511}
    }
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
`ifdef SUB_PER_HASH_SEQ_FLUSH_EN
    input  logic                 flush_i,
`endif
    sub_per_hash_seq_if.slave    bus,
    output logic                 busy_o
);

    if (NoRounds < 1) begin : g_err_rounds
        $error("sub_per_hash_seq: NoRounds must be >= 1");
    end
    if (InpWidth < 2 || InpWidth > MaxInpWidth) begin : g_err_width
        $error("sub_per_hash_seq: InpWidth out of range");
    end
    if (HashWidth < 1 || HashWidth > InpWidth) begin : g_err_hash
        $error("sub_per_hash_seq: HashWidth must be in 1..InpWidth");
    end

    // Counter keeps at least 5 bits so the XOR-key rotation index is always present.
    localparam int                      CntW      = (NoRounds > 32) ? $clog2(NoRounds) : 5;
    localparam logic [CntW-1:0]         LastRound = CntW'(NoRounds - 1);
    localparam logic [2**HashWidth-1:0] OneHot0   = {{(2**HashWidth-1){1'b0}}, 1'b1};

    function automatic logic [InpWidth-1:0] fold_sel(input int k);
        logic [InpWidth-1:0] sel;
        sel = '0;
        for (int j = 0; j < InpWidth; j++) begin
            if (j % HashWidth == k) sel[j] = 1'b1;
        end
        return sel;
    endfunction

    state_e                                state;
    logic [CntW-1:0]                       cnt;
    logic [NoHashes-1:0][InpWidth-1:0]     st;
    logic [NoHashes-1:0][InpWidth-1:0]     st_nxt;
    logic [NoHashes-1:0][HashWidth-1:0]    fold;
    logic [NoHashes-1:0][2**HashWidth-1:0] onehot_nxt;
    logic [NoHashes-1:0][HashWidth-1:0]    hash_q;
    logic [NoHashes-1:0][2**HashWidth-1:0] onehot_q;
    logic                                  out_valid_q;
    logic                                  busy_q;
    logic                                  in_ready;
    logic                                  in_fire;
    logic                                  flush;

`ifdef SUB_PER_HASH_SEQ_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Ready in DONE follows the consumer so a reload can share the output handshake.
    always_comb begin
        in_ready = 1'b0;
        unique case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = bus.out_ready_i;
            default: in_ready = 1'b0;
        endcase
        if (flush) in_ready = 1'b0;
    end

    assign in_fire = bus.in_valid_i & in_ready;

    for (genvar c = 0; c < NoHashes; c++) begin : g_ch
        sub_per_hash_round #(
            .InpWidth   (InpWidth),
            .PermuteKey (Seeds[c].PermuteSeed),
            .XorKey     (Seeds[c].XorSeed)
        ) u_round (
            .round_i (cnt[4:0]),
            .state_i (st[c]),
            .state_o (st_nxt[c])
        );

        for (genvar k = 0; k < HashWidth; k++) begin : g_fold
            localparam logic [InpWidth-1:0] Sel = fold_sel(k);
            assign fold[c][k] = ^(st_nxt[c] & Sel);
        end

        assign onehot_nxt[c] = OneHot0 << fold[c];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            st          <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            hash_q      <= '0;
            onehot_q    <= {NoHashes{OneHot0}};
        end else if (flush) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_fire) begin
                        st     <= {NoHashes{bus.in_data_i}};
                        cnt    <= '0;
                        state  <= BUSY;
                        busy_q <= 1'b1;
                    end
                end
                BUSY: begin
                    st  <= st_nxt;
                    cnt <= cnt + CntW'(1);
                    if (cnt == LastRound) begin
                        state       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        hash_q      <= fold;
                        onehot_q    <= onehot_nxt;
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (in_fire) begin
                            st     <= {NoHashes{bus.in_data_i}};
                            cnt    <= '0;
                            state  <= BUSY;
                            busy_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready_o    = in_ready;
    assign bus.out_valid_o   = out_valid_q;
    assign bus.hash_o        = hash_q;
    assign bus.hash_onehot_o = onehot_q;
    assign busy_o            = busy_q;

endmodule
